parity_serial_rx: RTL and testbench

Receive end of the team's single-wire serial link: turns an asynchronous, idle-high serial line back into parallel words. Each frame carries a start bit, LSB-first data, an optional parity bit and a stop bit. The block mid-bit samples at a fixed clocks-per-bit rate and checks parity with an XOR reduction. It holds the received word in a one-entry output buffer with a valid/ready handshake. It sits between the board-level input pin and any downstream parallel consumer.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/parity_serial_rx.sv | 172 +++++++++++++++++
 tb/tb_parity_serial_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (receiver and transmitter).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Callers zero-extend their word; zero padding does not change the XOR.
    function automatic logic parity_calc(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/parity_serial_rx.sv
// Serial receiver: mid-bit sampling, optional parity check, one-entry
// valid/ready output buffer with overrun reporting.
module parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o
);
    import serial_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic rx_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rx_prev_q, rx_prev_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              par_out_q, par_out_d;
    logic              frm_out_q, frm_out_d;
    logic              ovr_q, ovr_d;

    sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_prev_d = rx_s;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_prev_q == IDLE_LEVEL && rx_s == START_BIT) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    state_d = (rx_s == START_BIT) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = ((parity_calc(64'(shift_q)) ^ rx_s) != PAR_ODD);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave on the mid-bit sample so a start edge right after the stop bit is caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ferr_d  = (rx_s != STOP_BIT);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_out_d = par_out_q;
        frm_out_d = frm_out_q;
        ovr_d     = 1'b0;

        if (done_q && (!valid_q || ready_i)) begin
            data_d    = shift_q;
            par_out_d = perr_q;
            frm_out_d = ferr_q;
            valid_d   = 1'b1;
        end else if (done_q) begin
            ovr_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_prev_q <= IDLE_LEVEL;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_out_q <= 1'b0;
            frm_out_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_prev_q <= rx_prev_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_out_q <= par_out_d;
            frm_out_q <= frm_out_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = par_out_q;
    assign frame_err_o  = frm_out_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
// Scoreboard bench for parity_serial_rx: even-parity DUT plus an odd-parity copy on the same line.
module tb_parity_serial_rx;
    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b1;
    logic       ready_odd = 1'b1;
    logic [7:0] data_o, o_data;
    logic       valid_o, parity_err_o, frame_err_o, overrun_o;
    logic       o_valid, o_perr, o_ferr, o_ovr;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    int   hi_run = 0;
    int   hi_len = 0;
    int   ovr_cnt = 0;
    int   ovr_cyc = -1;
    logic valid_prev = 1'b0;
    int   c0, c2, c3;
    exp_t q_even[$];
    exp_t q_odd[$];

    parity_serial_rx u_dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    parity_serial_rx #(.PARITY_ODD(1)) u_odd (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (o_data),
        .valid_o      (o_valid),
        .ready_i      (ready_odd),
        .parity_err_o (o_perr),
        .frame_err_o  (o_ferr),
        .overrun_o    (o_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards on every handshake, tracks valid and overrun timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (q_even.size() == 0) begin
                    chk("even_unexpected_word", {24'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q_even.pop_front();
                    chk("even_data", {24'd0, data_o}, {24'd0, e.d});
                    chk("even_parity_err", {31'd0, parity_err_o}, {31'd0, e.pe});
                    chk("even_frame_err", {31'd0, frame_err_o}, {31'd0, e.fe});
                end
            end
            if (o_valid && ready_odd) begin
                if (q_odd.size() == 0) begin
                    chk("odd_unexpected_word", {24'd0, o_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q_odd.pop_front();
                    chk("odd_data", {24'd0, o_data}, {24'd0, e.d});
                    chk("odd_parity_err", {31'd0, o_perr}, {31'd0, e.pe});
                    chk("odd_frame_err", {31'd0, o_ferr}, {31'd0, e.fe});
                end
            end
            if (valid_o && !valid_prev) rise_cyc = cyc;
            if (valid_o) hi_run++;
            else if (hi_run > 0) begin
                hi_len = hi_run;
                hi_run = 0;
            end
            valid_prev = valid_o;
            if (overrun_o) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            if (o_ovr) chk("odd_overrun", 32'd1, 32'd0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        rx_i = 1'b1;
    endtask

    task automatic push_even(input logic [7:0] d, input logic pe, input logic fe);
        q_even.push_back('{d: d, pe: pe, fe: fe});
    endtask

    task automatic push_odd(input logic [7:0] d, input logic pe, input logic fe);
        q_odd.push_back('{d: d, pe: pe, fe: fe});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(3);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_data", {24'd0, data_o}, 32'd0);
        chk("reset_overrun", {31'd0, overrun_o}, 32'd0);
        rst = 1'b0;
        wait_cycles(CPB);

        // Clean frame: valid rises 172 edges after the drive point, for exactly one cycle.
        c0 = cyc;
        push_even(8'hA5, 1'b0, 1'b0);
        push_odd(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cycles(CPB);
        chk("clean_valid_rise_cycle", rise_cyc, c0 + 172);
        chk("clean_valid_high_len", hi_len, 32'd1);

        // Parity error on even, clean on odd.
        push_even(8'h01, 1'b1, 1'b0);
        push_odd(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cycles(CPB);

        // Frame error followed by a held-low break.
        push_even(8'h3C, 1'b0, 1'b1);
        push_odd(8'h3C, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_i = 1'b0;
        wait_cycles(3 * CPB);
        chk("break_no_valid", {31'd0, valid_o}, 32'd0);
        chk("break_one_word_only", q_even.size(), 32'd0);
        rx_i = 1'b1;
        wait_cycles(2 * CPB);

        // Glitch rejection.
        rx_i = 1'b0;
        wait_cycles(3);
        rx_i = 1'b1;
        wait_cycles(24);
        chk("glitch_state_idle", {29'd0, u_dut.state_q}, {29'd0, serial_pkg::IDLE});
        chk("glitch_no_valid", {31'd0, valid_o}, 32'd0);

        // Overrun: 0x22 dropped by the stalled even DUT.
        ready_i = 1'b0;
        push_even(8'h11, 1'b0, 1'b0);
        push_odd(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1);
        wait_cycles(CPB);
        c2 = cyc;
        push_odd(8'h22, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1);
        wait_cycles(CPB);
        chk("overrun_count", ovr_cnt, 32'd1);
        chk("overrun_cycle", ovr_cyc, c2 + 172);
        chk("overrun_retain_valid", {31'd0, valid_o}, 32'd1);
        chk("overrun_retain_data", {24'd0, data_o}, 32'h11);

        // Ready rises in the stop-sample cycle: 0x11 leaves and 0x33 loads on the same edge.
        c3 = cyc;
        push_even(8'h33, 1'b0, 1'b0);
        push_odd(8'h33, 1'b1, 1'b0);
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                wait (cyc == c3 + 171);
                #1;
                ready_i = 1'b1;
            end
        join
        wait_cycles(CPB);
        chk("handoff_no_overrun", ovr_cnt, 32'd1);

        // Leave a pending word, then reset in the middle of the 4th data bit.
        ready_i = 1'b0;
        push_odd(8'h44, 1'b1, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1);
        wait_cycles(CPB);
        chk("pending_valid", {31'd0, valid_o}, 32'd1);
        chk("pending_data", {24'd0, data_o}, 32'h44);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rx_i = 1'b0;
        wait_cycles(CPB / 2);
        rst = 1'b1;
        rx_i = 1'b1;
        @(negedge clk);
        chk("midreset_valid", {31'd0, valid_o}, 32'd0);
        chk("midreset_data", {24'd0, data_o}, 32'd0);
        chk("midreset_parity_err", {31'd0, parity_err_o}, 32'd0);
        chk("midreset_frame_err", {31'd0, frame_err_o}, 32'd0);
        chk("midreset_overrun", {31'd0, overrun_o}, 32'd0);
        wait_cycles(3);
        rst = 1'b0;
        ready_i = 1'b1;
        wait_cycles(2 * CPB);
        push_even(8'h5A, 1'b0, 1'b0);
        push_odd(8'h5A, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cycles(2 * CPB);

        chk("even_queue_drained", q_even.size(), 32'd0);
        chk("odd_queue_drained", q_odd.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
